// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch sequencer: word/address widths
// and the fetch FSM state encoding.
package fetch_unit_pkg;

  localparam int WORD_W     = 32;
  localparam int RAM_ADDR_W = 9;
  localparam int WCNT_W     = 8;

  typedef enum logic [2:0] {
    FETCH_IDLE  = 3'd0,
    FETCH_ADDR  = 3'd1,
    FETCH_WAIT  = 3'd2,
    FETCH_LATCH = 3'd3,
    FETCH_INC   = 3'd4
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_ir_reg.sv
// Load-enabled word register with async clear; used as the instruction
// register here and intended for reuse as the memory data register.
module ir_reg
  import fetch_unit_pkg::*;
#(
  parameter int W = WORD_W
) (
  input  logic         clk_i,
  input  logic         clr_i,
  input  logic         ld_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  always_ff @(posedge clk_i or posedge clr_i) begin
    if (clr_i) begin
      q_o <= '0;
    end else if (ld_i) begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: captures the PC, reads RAM with a bounded wait,
// loads the instruction register and pulses the PC increment.
//   state | meaning
//   IDLE  | waiting for fetch_req; address captured on accept
//   ADDR  | address settled, read strobe raised next
//   WAIT  | read outstanding, counting toward timeout
//   LATCH | word loaded; held here while stall is high
//   INC   | one-cycle pc_inc pulse, then back to IDLE
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int ADDR_W   = RAM_ADDR_W,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [WORD_W-1:0] pc_q,
  input  logic              fetch_req,
  input  logic              stall,
  input  logic [WORD_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic [WORD_W-1:0] ir_q,
  output logic              ir_valid,
  output logic              pc_inc,
  output logic              busy,
  output logic              fetch_err
);

  if (MAX_WAIT < 1 || MAX_WAIT > 255) begin : g_max_wait_chk
    $error("fetch_unit: MAX_WAIT must be in 1..255");
  end

  localparam logic [WCNT_W-1:0] MAX_CNT = WCNT_W'(MAX_WAIT);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              mem_rd_q, mem_rd_d;
  logic              ir_valid_q, ir_valid_d;
  logic              pc_inc_q, pc_inc_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic              ir_ld;

  logic unused_pc_hi;
  assign unused_pc_hi = ^pc_q[WORD_W-1:ADDR_W];

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wcnt_d     = wcnt_q;
    mem_rd_d   = mem_rd_q;
    ir_valid_d = 1'b0;
    pc_inc_d   = 1'b0;
    err_d      = err_q;
    ir_ld      = 1'b0;

    unique case (state_q)
      FETCH_IDLE: begin
        if (fetch_req) begin
          state_d = FETCH_ADDR;
          addr_d  = pc_q[ADDR_W-1:0];
          err_d   = 1'b0;
        end
      end
      FETCH_ADDR: begin
        state_d  = FETCH_WAIT;
        mem_rd_d = 1'b1;
        wcnt_d   = '0;
      end
      FETCH_WAIT: begin
        // A ready on the final allowed cycle still wins over the timeout.
        if (mem_ready) begin
          state_d    = FETCH_LATCH;
          ir_ld      = 1'b1;
          ir_valid_d = 1'b1;
          mem_rd_d   = 1'b0;
        end else if (wcnt_q == MAX_CNT) begin
          state_d  = FETCH_IDLE;
          err_d    = 1'b1;
          mem_rd_d = 1'b0;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      FETCH_LATCH: begin
        if (!stall) begin
          state_d  = FETCH_INC;
          pc_inc_d = 1'b1;
        end
      end
      FETCH_INC: begin
        state_d = FETCH_IDLE;
      end
      default: begin
        state_d  = FETCH_IDLE;
        mem_rd_d = 1'b0;
      end
    endcase

    busy_d = (state_d != FETCH_IDLE);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q    <= FETCH_IDLE;
      addr_q     <= '0;
      wcnt_q     <= '0;
      mem_rd_q   <= 1'b0;
      ir_valid_q <= 1'b0;
      pc_inc_q   <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wcnt_q     <= wcnt_d;
      mem_rd_q   <= mem_rd_d;
      ir_valid_q <= ir_valid_d;
      pc_inc_q   <= pc_inc_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  ir_reg #(.W(WORD_W)) u_ir (
    .clk_i (clk),
    .clr_i (clr),
    .ld_i  (ir_ld),
    .d_i   (mem_rdata),
    .q_o   (ir_q)
  );

  assign mem_addr  = addr_q;
  assign mem_rd    = mem_rd_q;
  assign ir_valid  = ir_valid_q;
  assign pc_inc    = pc_inc_q;
  assign busy      = busy_q;
  assign fetch_err = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios with literal
// expectations plus randomized traffic against a cycle-level reference model.
module tb_fetch_unit;

  localparam int ADDR_W   = 9;
  localparam int MAX_WAIT = 15;

  logic              clk = 1'b0;
  logic              clr = 1'b1;
  logic [31:0]       pc_q = '0;
  logic              fetch_req = 1'b0;
  logic              stall = 1'b0;
  logic [31:0]       mem_rdata = '0;
  logic              mem_ready = 1'b0;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [31:0]       ir_q;
  logic              ir_valid;
  logic              pc_inc;
  logic              busy;
  logic              fetch_err;

  int ncmp = 0;
  int nerr = 0;

  fetch_unit #(.ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk       (clk),
    .clr       (clr),
    .pc_q      (pc_q),
    .fetch_req (fetch_req),
    .stall     (stall),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .ir_q      (ir_q),
    .ir_valid  (ir_valid),
    .pc_inc    (pc_inc),
    .busy      (busy),
    .fetch_err (fetch_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a fetch is "accepted", spends one address cycle, then a
  // bounded number of read cycles, then holds the word until stall drops,
  // then spends one cycle handing the increment to the PC.
  logic [ADDR_W-1:0] m_addr = '0;
  logic [31:0]       m_ir = '0;
  bit m_active = 0, m_in_addr = 0, m_reading = 0, m_holding = 0;
  bit m_rd = 0, m_valid = 0, m_inc = 0, m_err = 0;
  int m_budget = 0;

  always @(posedge clk or posedge clr) begin
    if (clr) begin
      m_addr = '0; m_ir = '0;
      m_active = 0; m_in_addr = 0; m_reading = 0; m_holding = 0;
      m_rd = 0; m_valid = 0; m_inc = 0; m_err = 0; m_budget = 0;
    end else begin
      m_valid = 0;
      if (!m_active) begin
        if (fetch_req) begin
          m_active = 1; m_in_addr = 1; m_err = 0;
          m_addr = ADDR_W'(pc_q % (1 << ADDR_W));
        end
      end else if (m_in_addr) begin
        m_in_addr = 0; m_reading = 1; m_rd = 1; m_budget = MAX_WAIT + 1;
      end else if (m_reading) begin
        if (mem_ready) begin
          m_reading = 0; m_holding = 1; m_rd = 0; m_ir = mem_rdata; m_valid = 1;
        end else begin
          m_budget = m_budget - 1;
          if (m_budget == 0) begin
            m_reading = 0; m_active = 0; m_rd = 0; m_err = 1;
          end
        end
      end else if (m_holding) begin
        if (!stall) begin
          m_holding = 0; m_inc = 1;
        end
      end else begin
        m_inc = 0; m_active = 0;
      end
    end
  end

  always @(negedge clk) begin
    chk("mdl_mem_addr", 32'(mem_addr), 32'(m_addr));
    chk("mdl_mem_rd", 32'(mem_rd), 32'(m_rd));
    chk("mdl_ir_q", ir_q, m_ir);
    chk("mdl_ir_valid", 32'(ir_valid), 32'(m_valid));
    chk("mdl_pc_inc", 32'(pc_inc), 32'(m_inc));
    chk("mdl_busy", 32'(busy), 32'(m_active));
    chk("mdl_fetch_err", 32'(fetch_err), 32'(m_err));
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 60) begin
      tick();
      n++;
    end
    chk(name, 32'(busy), 32'd0);
  endtask

  initial begin
    int rdc, incs, vcnt, n;
    bit low_mode;

    repeat (2) @(posedge clk);
    #2 clr = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ir_q", ir_q, 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);

    // Zero-wait fetch
    pc_q = 32'h0000_0005; fetch_req = 1'b1;
    tick();
    chk("zw_busy", 32'(busy), 32'd1);
    chk("zw_mem_addr", 32'(mem_addr), 32'd5);
    chk("zw_model_addr", 32'(m_addr), 32'd5);
    chk("zw_rd_addr_cycle", 32'(mem_rd), 32'd0);
    fetch_req = 1'b0;
    tick();
    chk("zw_rd_wait", 32'(mem_rd), 32'd1);
    mem_ready = 1'b1; mem_rdata = 32'h1234_5678;
    tick();
    chk("zw_ir_q", ir_q, 32'h1234_5678);
    chk("zw_model_ir", m_ir, 32'h1234_5678);
    chk("zw_ir_valid", 32'(ir_valid), 32'd1);
    chk("zw_rd_done", 32'(mem_rd), 32'd0);
    mem_ready = 1'b0; mem_rdata = 32'hDEAD_BEEF;
    tick();
    chk("zw_pc_inc", 32'(pc_inc), 32'd1);
    chk("zw_valid_once", 32'(ir_valid), 32'd0);
    tick();
    chk("zw_pc_inc_off", 32'(pc_inc), 32'd0);
    chk("zw_busy_off", 32'(busy), 32'd0);

    // Three wait states
    pc_q = 32'h0000_0123; fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    rdc = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (mem_rd) rdc++;
      if (i == 3) chk("ws_ir_hold", ir_q, 32'h1234_5678);
      if (i == 4) chk("ws_ir_valid", 32'(ir_valid), 32'd1);
      mem_ready = (i == 3);
      mem_rdata = (i == 3) ? 32'hA5A5_0003 : 32'h0BAD_0BAD;
    end
    chk("ws_rd_cycles", 32'(rdc), 32'd4);
    chk("ws_ir_q", ir_q, 32'hA5A5_0003);
    chk("ws_mem_addr", 32'(mem_addr), 32'h123);

    // Timeout
    mem_ready = 1'b0; pc_q = 32'h0000_0077; fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    rdc = 0; incs = 0; n = 0;
    while (busy && n < 40) begin
      tick();
      if (mem_rd) rdc++;
      if (pc_inc) incs++;
      n++;
    end
    chk("to_cycles", 32'(n), 32'd17);
    chk("to_rd_cycles", 32'(rdc), 32'd16);
    chk("to_err", 32'(fetch_err), 32'd1);
    chk("to_no_inc", 32'(incs), 32'd0);
    chk("to_ir_kept", ir_q, 32'hA5A5_0003);
    tick();
    chk("to_err_sticky", 32'(fetch_err), 32'd1);
    fetch_req = 1'b1;
    tick();
    chk("to_err_clear", 32'(fetch_err), 32'd0);
    fetch_req = 1'b0; mem_ready = 1'b1; mem_rdata = 32'hCAFE_F00D;
    tick(); tick();
    mem_ready = 1'b0;
    wait_idle("to_drain");
    chk("to_refetch_ir", ir_q, 32'hCAFE_F00D);

    // Stall on LATCH entry
    pc_q = 32'h0000_0040; fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0; stall = 1'b1;
    tick();
    mem_ready = 1'b1; mem_rdata = 32'h5555_AAAA;
    tick();
    vcnt = ir_valid ? 1 : 0;
    mem_ready = 1'b0;
    incs = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (ir_valid) vcnt++;
      if (pc_inc) incs++;
    end
    chk("st_no_inc", 32'(incs), 32'd0);
    stall = 1'b0;
    tick();
    chk("st_pc_inc", 32'(pc_inc), 32'd1);
    chk("st_valid_once", 32'(vcnt), 32'd1);
    tick();
    chk("st_pc_inc_off", 32'(pc_inc), 32'd0);

    // Address wrap and capture-once
    pc_q = 32'h0000_0200; fetch_req = 1'b1;
    tick();
    chk("wr_mem_addr", 32'(mem_addr), 32'd0);
    chk("wr_model_addr", 32'(m_addr), 32'd0);
    fetch_req = 1'b0; pc_q = 32'h0000_01FF;
    tick(); tick();
    chk("wr_addr_held", 32'(mem_addr), 32'd0);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    wait_idle("wr_drain");

    // Async clear mid-read
    pc_q = 32'h0000_0033; fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    tick(); tick();
    chk("cl_pre_rd", 32'(mem_rd), 32'd1);
    clr = 1'b1;
    #1;
    chk("cl_mem_addr", 32'(mem_addr), 32'd0);
    chk("cl_mem_rd", 32'(mem_rd), 32'd0);
    chk("cl_ir_q", ir_q, 32'd0);
    chk("cl_ir_valid", 32'(ir_valid), 32'd0);
    chk("cl_pc_inc", 32'(pc_inc), 32'd0);
    chk("cl_busy", 32'(busy), 32'd0);
    chk("cl_fetch_err", 32'(fetch_err), 32'd0);
    tick();
    clr = 1'b0;
    incs = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (pc_inc || busy) incs++;
    end
    chk("cl_quiet_after", 32'(incs), 32'd0);

    // Randomized traffic
    low_mode = 0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (c % 150 == 0) low_mode = ~low_mode;
      if (clr) clr = 1'b0;
      else if ($urandom_range(0, 299) == 0) clr = 1'b1;
      fetch_req = ($urandom_range(0, 3) != 0);
      stall     = ($urandom_range(0, 3) == 0);
      mem_ready = low_mode ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 1) == 1);
      mem_rdata = $urandom;
      pc_q      = $urandom;
    end
    clr = 1'b0; fetch_req = 1'b0; stall = 1'b0; mem_ready = 1'b1;
    wait_idle("final_drain");
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
